start_stop_ctrl: RTL and testbench

Clean front end for the lab counter's START/STOP control. It takes two raw mechanical push-buttons, START/STOP and CLEAR, and processes them in three steps: synchronise to clk, debounce, detect the press edge. It then runs a three-state run controller. Its outputs are a level `run` enable and a one-cycle `clear` pulse for the counter core. It replaces any button-clocked toggle logic, so every state element sits in the clk domain.

---
 rtl/start_stop_ctrl.sv | 96 +++++++++
 tb/tb_start_stop_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/start_stop_ctrl.sv
// START/STOP front end: two-flop sync, debounce and press detect per button,
// feeding an IDLE/RUN/STOP controller with a one-cycle clear pulse.
module start_stop_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic       run,
  output logic       clear,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STOP = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries START/STOP, bit 1 carries CLEAR through every stage.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [1:0]       r_db_d;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_cnt [2];

  logic [1:0] r_state;
  logic       r_run;
  logic       r_clear;
  logic [1:0] w_next;
  logic       w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {btn_clear, btn_start};
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear press overrides a coincident start press.
  always_comb begin
    w_clr  = r_press[1];
    w_next = r_state;
    if (w_clr) begin
      w_next = S_IDLE;
    end else if (r_press[0]) begin
      case (r_state)
        S_IDLE:  w_next = S_RUN;
        S_RUN:   w_next = S_STOP;
        S_STOP:  w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= (w_next == S_RUN);
      r_clear <= w_clr;
    end
  end

  assign run   = r_run;
  assign clear = r_clear;
  assign state = r_state;

endmodule

// File: tb/tb_start_stop_ctrl.sv
// Directed bench for start_stop_ctrl with DEBOUNCE_CYCLES=4 (press-to-output latency 8 edges).
module tb_start_stop_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_start;
  logic       btn_clear;
  logic       run;
  logic       clear;
  logic [1:0] state;

  int n_vec;
  int n_err;
  int n_clr;

  start_stop_ctrl #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .run       (run),
    .clear     (clear),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {clear, run, state}.
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    btn_start = 1'b1;
    repeat (n) step();
    btn_start = 1'b0;
    repeat (14) step();
  endtask

  initial begin
    logic [5:0] bounce;
    n_vec = 0;
    n_err = 0;
    n_clr = 0;
    rst_n = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (3) step();
    check("reset", {clear, run, state}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_quiet", {clear, run, state}, 4'b0000);
    end

    // First start press: exact latency
    btn_start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 7) check("start_lat7", {clear, run, state}, 4'b0000);
      if (i >= 8) check("start_held", {clear, run, state}, 4'b0101);
    end
    btn_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      check("start_release", {clear, run, state}, 4'b0101);
    end

    pulse_start(6);
    check("run_to_stop", {clear, run, state}, 4'b0010);
    pulse_start(6);
    check("stop_to_run", {clear, run, state}, 4'b0101);

    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      btn_start = bounce[i];
      step();
    end
    btn_start = 1'b0;
    repeat (14) step();
    check("bounce_reject", {clear, run, state}, 4'b0101);
    pulse_start(3);
    check("pulse3_reject", {clear, run, state}, 4'b0101);
    pulse_start(4);
    check("pulse4_accept", {clear, run, state}, 4'b0010);
    pulse_start(6);
    check("resume_run", {clear, run, state}, 4'b0101);

    // Simultaneous start + clear while RUN
    btn_start = 1'b1;
    btn_clear = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (clear) n_clr++;
      if (i == 7) check("both_lat7", {clear, run, state}, 4'b0101);
      if (i == 8) check("both_clear", {clear, run, state}, 4'b1000);
      if (i == 9) check("both_after", {clear, run, state}, 4'b0000);
    end
    btn_start = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (clear) n_clr++;
    end
    check("both_pulses", 4'(n_clr), 4'd1);
    check("both_final", {clear, run, state}, 4'b0000);

    btn_clear = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) check("idle_clr_lat7", {clear, run, state}, 4'b0000);
      if (i == 8) check("idle_clr_pulse", {clear, run, state}, 4'b1000);
      if (i == 9) check("idle_clr_after", {clear, run, state}, 4'b0000);
    end
    btn_clear = 1'b0;
    repeat (14) step();
    check("idle_clr_final", {clear, run, state}, 4'b0000);

    // Reset mid-debounce while RUN, button kept held
    pulse_start(6);
    check("pre_reset_run", {clear, run, state}, 4'b0101);
    btn_start = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("async_reset", {clear, run, state}, 4'b0000);
    repeat (2) step();
    check("reset_held", {clear, run, state}, 4'b0000);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("post_rst_lat7", {clear, run, state}, 4'b0000);
      if (i == 8) check("post_rst_run", {clear, run, state}, 4'b0101);
    end
    btn_start = 1'b0;
    repeat (14) step();
    check("post_rst_final", {clear, run, state}, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
